// File: rtl/lift_scan_ctrl.sv
// N-floor elevator controller: registered pending requests, SCAN sweep service,
// per-floor travel timer and a reloadable timed door cycle.
module lift_scan_ctrl #(
    parameter int unsigned FLOORS   = 4,
    parameter int unsigned FLR_W    = 2,
    parameter int unsigned MOVE_CYC = 2,
    parameter int unsigned DOOR_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] req,
    output logic [1:0]        motor,
    output logic [FLR_W-1:0]  floor,
    output logic              door_open,
    output logic              arrive,
    output logic              idle,
    output logic [FLOORS-1:0] pending
);

    localparam int unsigned MtW = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
    localparam int unsigned DtW = $clog2(DOOR_CYC + 1);
    localparam logic DirUp = 1'b0;

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e            state_q, state_d;
    logic [FLR_W-1:0]  floor_q, floor_d, floor_step;
    logic              dir_q, dir_d;
    logic [MtW-1:0]    mtimer_q, mtimer_d;
    logic [DtW-1:0]    dtimer_q, dtimer_d;
    logic              arrive_q, arrive_d;
    logic [FLOORS-1:0] pending_q, pending_d;

    logic [FLOORS-1:0] above, below, cur_oh, step_oh, clr_oh, ahead, behind, req_eff;
    logic              enter_door;

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        mtimer_d   = mtimer_q;
        dtimer_d   = dtimer_q;
        arrive_d   = 1'b0;
        enter_door = 1'b0;
        above      = '0;
        below      = '0;
        cur_oh     = '0;
        step_oh    = '0;
        clr_oh     = '0;

        floor_step = (dir_q == DirUp) ? floor_q + FLR_W'(1) : floor_q - FLR_W'(1);
        for (int i = 0; i < FLOORS; i++) begin
            above[i]   = (FLR_W'(i) > floor_q);
            below[i]   = (FLR_W'(i) < floor_q);
            cur_oh[i]  = (FLR_W'(i) == floor_q);
            step_oh[i] = (FLR_W'(i) == floor_step);
        end
        ahead  = pending_q & ((dir_q == DirUp) ? above : below);
        behind = pending_q & ((dir_q == DirUp) ? below : above);

        unique case (state_q)
            StIdle: begin
                if (|(pending_q & cur_oh)) begin
                    enter_door = 1'b1;
                end else if (|ahead) begin
                    state_d  = StMove;
                    mtimer_d = '0;
                end else if (|behind) begin
                    state_d  = StMove;
                    mtimer_d = '0;
                    dir_d    = ~dir_q;
                end
            end
            StMove: begin
                if (mtimer_q == MtW'(MOVE_CYC - 1)) begin
                    mtimer_d = '0;
                    floor_d  = floor_step;
                    // Arrival uses the registered vector: a request must be latched beforehand
                    if (|(pending_q & step_oh)) begin
                        enter_door = 1'b1;
                    end
                end else begin
                    mtimer_d = mtimer_q + MtW'(1);
                end
            end
            StDoor: begin
                if (|(req & cur_oh)) begin
                    dtimer_d = DtW'(DOOR_CYC);
                end else if (dtimer_q == DtW'(1)) begin
                    dtimer_d = '0;
                    if (|ahead) begin
                        state_d = StMove;
                    end else if (|behind) begin
                        state_d = StMove;
                        dir_d   = ~dir_q;
                    end else begin
                        state_d = StIdle;
                    end
                    mtimer_d = '0;
                end else begin
                    dtimer_d = dtimer_q - DtW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_door) begin
            state_d  = StDoor;
            dtimer_d = DtW'(DOOR_CYC);
            arrive_d = 1'b1;
            clr_oh   = (state_q == StIdle) ? cur_oh : step_oh;
        end

        // A call for the floor whose door is already open only extends the door cycle
        req_eff   = (state_q == StDoor) ? (req & ~cur_oh) : req;
        pending_d = (pending_q & ~clr_oh) | req_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            floor_q   <= '0;
            dir_q     <= DirUp;
            mtimer_q  <= '0;
            dtimer_q  <= '0;
            arrive_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            mtimer_q  <= mtimer_d;
            dtimer_q  <= dtimer_d;
            arrive_q  <= arrive_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        motor = 2'b00;
        if (state_q == StMove) begin
            motor = (dir_q == DirUp) ? 2'b01 : 2'b10;
        end
    end

    assign floor     = floor_q;
    assign door_open = (state_q == StDoor);
    assign idle      = (state_q == StIdle);
    assign arrive    = arrive_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed self-checking bench for lift_scan_ctrl (FLOORS=4, MOVE_CYC=2, DOOR_CYC=4).
module tb_lift_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] motor;
    logic [1:0] floor;
    logic       door_open;
    logic       arrive;
    logic       idle;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    int cnt;

    lift_scan_ctrl #(
        .FLOORS  (4),
        .FLR_W   (2),
        .MOVE_CYC(2),
        .DOOR_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .motor    (motor),
        .floor    (floor),
        .door_open(door_open),
        .arrive   (arrive),
        .idle     (idle),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        chk("rst_idle", idle, 1);
        chk("rst_floor", floor, 0);
        chk("rst_motor", motor, 0);
        chk("rst_pending", pending, 0);
        chk("rst_door", door_open, 0);
        chk("rst_arrive", arrive, 0);
        rst_n = 1'b1;

        // 1: call at current floor
        req = 4'b0001;
        tick();
        req = '0;
        chk("t1_pending", pending, 4'b0001);
        chk("t1_idle", idle, 1);
        chk("t1_motor0", motor, 0);
        tick();
        chk("t1_door", door_open, 1);
        chk("t1_arrive", arrive, 1);
        chk("t1_clear", pending, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_door_hold", door_open, 1);
            chk("t1_arrive_once", arrive, 0);
            chk("t1_motor", motor, 0);
        end
        tick();
        chk("t1_back_idle", idle, 1);
        chk("t1_door_off", door_open, 0);

        // 2: 0 -> 3
        req = 4'b1000;
        tick();
        req = '0;
        chk("t2_pending", pending, 4'b1000);
        chk("t2_motor_wait", motor, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t2_motor_up", motor, 2'b01);
            chk("t2_floor", floor, (k - 1) / 2);
        end
        tick();
        chk("t2_floor3", floor, 3);
        chk("t2_door", door_open, 1);
        chk("t2_arrive", arrive, 1);
        chk("t2_motor_stop", motor, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_door_hold", door_open, 1);
        end
        tick();
        chk("t2_idle", idle, 1);
        chk("t2_pending0", pending, 0);

        // From floor 3 idle, a call below reverses direction
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("t2b_motor_down", motor, 2'b10);

        // 3: two stops in SCAN order
        do_reset();
        req = 4'b1010;
        tick();
        req = '0;
        chk("t3_pending", pending, 4'b1010);
        tick();
        chk("t3_move", motor, 2'b01);
        tick();
        tick();
        chk("t3_floor1", floor, 1);
        chk("t3_door1", door_open, 1);
        chk("t3_pend1", pending, 4'b1000);
        repeat (3) tick();
        chk("t3_door1_end", door_open, 1);
        tick();
        chk("t3_move2", motor, 2'b01);
        chk("t3_move2_floor", floor, 1);
        tick();
        tick();
        chk("t3_floor2", floor, 2);
        chk("t3_pass2", motor, 2'b01);
        tick();
        tick();
        chk("t3_floor3", floor, 3);
        chk("t3_door3", door_open, 1);
        chk("t3_pend0", pending, 0);
        repeat (4) tick();
        chk("t3_idle", idle, 1);

        // 4: late request behind the car
        do_reset();
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("t4_floor1", floor, 1);
        req = 4'b0001;
        tick();
        req = '0;
        chk("t4_pending", pending, 4'b1001);
        tick();
        chk("t4_floor2", floor, 2);
        chk("t4_no_rev", motor, 2'b01);
        tick();
        tick();
        chk("t4_floor3", floor, 3);
        chk("t4_door3", door_open, 1);
        chk("t4_pend_hold", pending, 4'b0001);
        repeat (3) tick();
        tick();
        chk("t4_motor_down", motor, 2'b10);
        chk("t4_start_floor", floor, 3);
        tick();
        tick();
        chk("t4_floor2_down", floor, 2);
        chk("t4_pass2", motor, 2'b10);
        repeat (4) tick();
        chk("t4_floor0", floor, 0);
        chk("t4_door0", door_open, 1);
        chk("t4_arrive0", arrive, 1);
        chk("t4_pend0", pending, 0);
        repeat (4) tick();
        chk("t4_idle", idle, 1);

        // 5: door reload by a call for the open floor
        do_reset();
        req = 4'b0100;
        tick();
        req = '0;
        repeat (5) tick();
        chk("t5_floor2", floor, 2);
        chk("t5_door", door_open, 1);
        cnt = 1;
        tick();
        cnt++;
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            req = '0;
            if (!door_open) break;
            cnt++;
        end
        chk("t5_door_len", cnt, 6);
        chk("t5_pend0", pending, 0);
        chk("t5_idle", idle, 1);

        // 6: async reset mid-move
        do_reset();
        req = 4'b1000;
        tick();
        req = '0;
        repeat (4) tick();
        chk("t6_floor1", floor, 1);
        chk("t6_moving", motor, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("t6_floor", floor, 0);
        chk("t6_motor", motor, 0);
        chk("t6_pending", pending, 0);
        chk("t6_idle", idle, 1);
        chk("t6_door", door_open, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_stay_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
